alu_operand_loader: RTL and testbench

Sequential front end for the team's 32-bit combinational ALU on the switch/LED test board. It loads operands A and B one byte at a time from 8 switches, each byte strobed by a debounced button pulse. On a start strobe it presents the operands and opcode to the ALU, then registers the result and the ZF/OF flags. Its outputs drive the ALU inputs, and its captured result feeds the LED byte-select mux.

---
 rtl/alu_operand_loader_if.sv | 37 +++
 rtl/alu_operand_loader.sv | 162 ++++++++++++++++
 tb/tb_alu_operand_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_loader_if.sv
// Operand-loader <-> board/ALU signal bundle: switch/button strobes in, ALU operands out, ALU result back.
// The slave modport is the loader's view; the master modport is the board/ALU side.
interface alu_operand_loader_if #(
  parameter int BYTES = 4,
  parameter int IDX_W = 3
) ();
  localparam int W = 8 * BYTES;

  logic [7:0]       sw_data;
  logic             load_pulse;
  logic [2:0]       op_in;
  logic             start;
  logic             clear;
  logic [W-1:0]     alu_F;
  logic             alu_ZF;
  logic             alu_OF;
  logic [W-1:0]     A_out;
  logic [W-1:0]     B_out;
  logic [2:0]       ALU_OP_out;
  logic [W-1:0]     result;
  logic             ZF_q;
  logic             OF_q;
  logic             res_valid;
  logic             busy;
  logic [2:0]       state_o;
  logic [IDX_W-1:0] byte_idx;

  modport master (
    output sw_data, load_pulse, op_in, start, clear, alu_F, alu_ZF, alu_OF,
    input  A_out, B_out, ALU_OP_out, result, ZF_q, OF_q, res_valid, busy, state_o, byte_idx
  );

  modport slave (
    input  sw_data, load_pulse, op_in, start, clear, alu_F, alu_ZF, alu_OF,
    output A_out, B_out, ALU_OP_out, result, ZF_q, OF_q, res_valid, busy, state_o, byte_idx
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Byte-serial operand loader and result capture for a combinational ALU; result valid 2 edges after start.
// No backpressure: strobes are single-cycle events, ignored in states that do not accept them.
module alu_operand_loader #(
  parameter int BYTES = 4,
  parameter int IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_operand_loader_if.slave   bus
);
  localparam int W = 8 * BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    READY  = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     result_q, result_d;
  logic             zf_q, zf_d;
  logic             of_q, of_d;
  logic             res_valid_q, res_valid_d;

  // Little-endian byte insert: byte k lands in bits [8k+7:8k], others untouched.
  function automatic logic [W-1:0] put_byte(input logic [W-1:0]     v,
                                            input logic [IDX_W-1:0] k,
                                            input logic [7:0]       d);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < BYTES; i++) begin
      if (k == IDX_W'(i)) r[8*i +: 8] = d;
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    zf_d        = zf_q;
    of_d        = of_q;
    res_valid_d = res_valid_q;

    if (bus.clear) begin
      state_d     = LOAD_A;
      byte_idx_d  = '0;
      a_d         = '0;
      b_d         = '0;
      result_d    = '0;
      zf_d        = 1'b0;
      of_d        = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (bus.load_pulse) begin
            a_d = put_byte(a_q, byte_idx_q, bus.sw_data);
            if (byte_idx_q == LAST_IDX) begin
              byte_idx_d = '0;
              state_d    = LOAD_B;
            end else begin
              byte_idx_d = byte_idx_q + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (bus.load_pulse) begin
            b_d = put_byte(b_q, byte_idx_q, bus.sw_data);
            if (byte_idx_q == LAST_IDX) begin
              byte_idx_d = '0;
              state_d    = READY;
            end else begin
              byte_idx_d = byte_idx_q + IDX_W'(1);
            end
          end
        end
        READY: begin
          if (bus.start) begin
            op_d    = bus.op_in;
            state_d = EXEC;
          end
        end
        EXEC: begin
          // One settle cycle on stable operands, then capture.
          result_d    = bus.alu_F;
          zf_d        = bus.alu_ZF;
          of_d        = bus.alu_OF;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (bus.start) begin
            op_d        = bus.op_in;
            res_valid_d = 1'b0;
            state_d     = EXEC;
          end else if (bus.load_pulse) begin
            // New A entry starts immediately with this byte as A[7:0]; B is kept.
            res_valid_d = 1'b0;
            a_d         = put_byte(a_q, '0, bus.sw_data);
            if (BYTES == 1) begin
              byte_idx_d = '0;
              state_d    = LOAD_B;
            end else begin
              byte_idx_d = IDX_W'(1);
              state_d    = LOAD_A;
            end
          end
        end
        default: begin
          state_d    = LOAD_A;
          byte_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      byte_idx_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      zf_q        <= 1'b0;
      of_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      zf_q        <= zf_d;
      of_q        <= of_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.A_out      = a_q;
  assign bus.B_out      = b_q;
  assign bus.ALU_OP_out = op_q;
  assign bus.result     = result_q;
  assign bus.ZF_q       = zf_q;
  assign bus.OF_q       = of_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.busy       = (state_q == EXEC);
  assign bus.state_o    = state_q;
  assign bus.byte_idx   = byte_idx_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a behavioural stand-in for the team ALU.
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
module tb_alu_operand_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_operand_loader_if #(.BYTES(4), .IDX_W(3)) bus ();

  alu_operand_loader #(.BYTES(4), .IDX_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU model: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB, 6 SLT (signed), 7 pass B.
  always_comb begin
    logic [31:0] a, b, f;
    logic        ov;
    a  = bus.A_out;
    b  = bus.B_out;
    f  = '0;
    ov = 1'b0;
    case (bus.ALU_OP_out)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = a ^ b;
      3'd3: f = ~(a | b);
      3'd4: begin f = a + b; ov = (a[31] == b[31]) && (f[31] != a[31]); end
      3'd5: begin f = a - b; ov = (a[31] != b[31]) && (f[31] != a[31]); end
      3'd6: f = {31'b0, ($signed(a) < $signed(b))};
      default: f = b;
    endcase
    bus.alu_F  = f;
    bus.alu_OF = ov;
    bus.alu_ZF = (f == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] d);
    bus.sw_data    = d;
    bus.load_pulse = 1'b1;
    tick();
    bus.load_pulse = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) load_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start(input logic [2:0] op);
    bus.op_in = op;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sw_data    = '0;
    bus.load_pulse = 1'b0;
    bus.op_in      = '0;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_state", bus.state_o, 0);
    check("rst_idx", bus.byte_idx, 0);
    check("rst_A", bus.A_out, 0);
    check("rst_B", bus.B_out, 0);
    check("rst_result", bus.result, 0);
    check("rst_op", bus.ALU_OP_out, 0);
    check("rst_flags", {bus.ZF_q, bus.OF_q, bus.res_valid, bus.busy}, 0);

    // Async reset in the middle of loading A
    load_byte(8'h11);
    load_byte(8'h22);
    check("partA_val", bus.A_out, 32'h0000_2211);
    check("partA_idx", bus.byte_idx, 2);
    rst = 1'b1;
    #1;
    check("midrst_A", bus.A_out, 0);
    check("midrst_idx", bus.byte_idx, 0);
    check("midrst_state", bus.state_o, 0);
    check("midrst_valid", bus.res_valid, 0);
    tick();
    rst = 1'b0;
    tick();

    // start in LOAD_A is ignored
    pulse_start(3'd4);
    check("startA_state", bus.state_o, 0);

    // Load A = 0x12345678
    load_word(32'h1234_5678);
    check("A_val", bus.A_out, 32'h1234_5678);
    check("A_to_B_state", bus.state_o, 1);
    check("A_to_B_idx", bus.byte_idx, 0);

    // start during LOAD_B ignored
    load_byte(8'h22);
    pulse_start(3'd4);
    check("startB_state", bus.state_o, 1);
    check("startB_idx", bus.byte_idx, 1);
    check("startB_op", bus.ALU_OP_out, 0);
    load_byte(8'h22);
    load_byte(8'h33);
    load_byte(8'h33);
    check("B_val", bus.B_out, 32'h3333_2222);
    check("ready_state", bus.state_o, 2);

    // load_pulse in READY dropped
    load_byte(8'hFF);
    check("ldready_state", bus.state_o, 2);
    check("ldready_A", bus.A_out, 32'h1234_5678);
    check("ldready_B", bus.B_out, 32'h3333_2222);
    check("ldready_idx", bus.byte_idx, 0);

    // ADD: one cycle in EXEC, then capture
    pulse_start(3'd4);
    check("exec_state", bus.state_o, 3);
    check("exec_busy", bus.busy, 1);
    check("exec_op", bus.ALU_OP_out, 4);
    check("exec_valid", bus.res_valid, 0);
    load_byte(8'hEE); // load during EXEC ignored
    check("done_state", bus.state_o, 4);
    check("add_result", bus.result, 32'h4567_789A);
    check("add_flags", {bus.ZF_q, bus.OF_q}, 2'b00);
    check("add_valid", bus.res_valid, 1);
    check("done_busy", bus.busy, 0);
    check("ldexec_A", bus.A_out, 32'h1234_5678);
    check("ldexec_idx", bus.byte_idx, 0);

    // load_pulse in DONE begins a new A
    load_byte(8'hAA);
    check("ldone_state", bus.state_o, 0);
    check("ldone_A", bus.A_out, 32'h1234_56AA);
    check("ldone_idx", bus.byte_idx, 1);
    check("ldone_valid", bus.res_valid, 0);
    check("ldone_B", bus.B_out, 32'h3333_2222);

    // clear zeroes operands and result, keeps opcode
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_state", bus.state_o, 0);
    check("clr_A", bus.A_out, 0);
    check("clr_B", bus.B_out, 0);
    check("clr_result", bus.result, 0);
    check("clr_op", bus.ALU_OP_out, 4);

    // Signed overflow on ADD, then re-execute SUB from DONE
    load_word(32'h7FFF_FFFF);
    load_word(32'h7FFF_FFFF);
    pulse_start(3'd4);
    tick();
    check("ovf_result", bus.result, 32'hFFFF_FFFE);
    check("ovf_flags", {bus.ZF_q, bus.OF_q, bus.res_valid}, 3'b011);
    pulse_start(3'd5);
    check("rerun_state", bus.state_o, 3);
    check("rerun_valid", bus.res_valid, 0);
    check("rerun_op", bus.ALU_OP_out, 5);
    tick();
    check("sub_result", bus.result, 0);
    check("sub_flags", {bus.ZF_q, bus.OF_q, bus.res_valid}, 3'b101);

    // In DONE, start beats load_pulse
    bus.sw_data    = 8'h55;
    bus.load_pulse = 1'b1;
    pulse_start(3'd4);
    bus.load_pulse = 1'b0;
    check("prio_state", bus.state_o, 3);
    check("prio_A", bus.A_out, 32'h7FFF_FFFF);
    tick();
    check("prio_result", bus.result, 32'hFFFF_FFFE);

    // clear + start together in READY
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr2_OF", bus.OF_q, 0);
    load_word(32'h0403_0201);
    load_word(32'h0807_0605);
    check("ready2_state", bus.state_o, 2);
    bus.clear = 1'b1;
    pulse_start(3'd6);
    bus.clear = 1'b0;
    check("clrst_state", bus.state_o, 0);
    check("clrst_A", bus.A_out, 0);
    check("clrst_B", bus.B_out, 0);
    check("clrst_busy", bus.busy, 0);
    check("clrst_op", bus.ALU_OP_out, 4);
    tick();
    check("clrst_valid", bus.res_valid, 0);
    check("clrst_result", bus.result, 0);
    check("clrst_state2", bus.state_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
